i2c_bus_cond_detector: RTL and testbench

- Synchronous, parametrised detector for I2C bus conditions (START, repeated START, STOP).
- Runs entirely on the system clock; replaces the older asynchronous, SDA-clocked stop detection.
- Adds input synchronisation, glitch filtering, repeated-START discrimination, bus-busy tracking and a bus-free timer.
- Sits between the I2C pads and the EEPROM slave / master protocol FSMs.

---
 rtl/i2c_bus_cond_detector_pkg.sv | 25 ++
 rtl/i2c_line_filter.sv | 46 ++++
 rtl/i2c_bus_cond_detector.sv | 113 +++++++++++
 tb/tb_i2c_bus_cond_detector.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_bus_cond_detector_pkg.sv
// rtl/i2c_bus_cond_detector_pkg.sv - shared constants, types and width helper for the I2C condition detector
package i2c_bus_cond_detector_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        COND_NONE   = 2'd0,
        COND_START  = 2'd1,
        COND_RSTART = 2'd2,
        COND_STOP   = 2'd3
    } bus_cond_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchroniser plus stable-count glitch filter for one I2C line
module i2c_line_filter
    import i2c_bus_cond_detector_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic line_filt
);

    localparam int                FCNT_W   = clog2(FILT_LEN) + 1;
    localparam logic [FCNT_W-1:0] CNT_LAST = FCNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_s;
    logic [FCNT_W-1:0]      cnt;

    assign line_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
        end
    end

    // The filtered line only moves after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_filt <= IDLE_LEVEL;
            cnt       <= '0;
        end else if (line_s == line_filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            line_filt <= line_s;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_bus_cond_detector.sv
// rtl/i2c_bus_cond_detector.sv - synchronous I2C START / repeated START / STOP detector with busy and bus-free tracking
module i2c_bus_cond_detector
    import i2c_bus_cond_detector_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int FILT_LEN        = 3,
    parameter int BUS_FREE_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_filt,
    output logic sda_filt,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_pulse,
    output logic rstart_pulse,
    output logic stop_pulse,
    output logic bus_busy,
    output logic bus_free
);

    localparam int                BCNT_W    = clog2(BUS_FREE_CYCLES) + 1;
    localparam logic [BCNT_W-1:0] FREE_LAST = BCNT_W'(BUS_FREE_CYCLES - 1);
    localparam logic [BCNT_W-1:0] FREE_SAT  = BCNT_W'(BUS_FREE_CYCLES);

    logic              scl_p;
    logic              sda_p;
    logic              start_cond;
    logic              stop_cond;
    bus_cond_e         cond;
    logic [BCNT_W-1:0] free_cnt;

    i2c_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_scl_filter (
        .clk      (clk),
        .reset    (reset),
        .line_in  (scl_in),
        .line_filt(scl_filt)
    );

    i2c_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_sda_filter (
        .clk      (clk),
        .reset    (reset),
        .line_in  (sda_in),
        .line_filt(sda_filt)
    );

    // SCL must be high both before and after the SDA edge, so a joint SCL/SDA change is never a condition.
    assign start_cond = enable && sda_p && !sda_filt && scl_p && scl_filt;
    assign stop_cond  = enable && !sda_p && sda_filt && scl_p && scl_filt;

    always_comb begin
        cond = COND_NONE;
        if (start_cond) begin
            cond = bus_busy ? COND_RSTART : COND_START;
        end else if (stop_cond) begin
            cond = COND_STOP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_p        <= IDLE_LEVEL;
            sda_p        <= IDLE_LEVEL;
            scl_rise     <= 1'b0;
            scl_fall     <= 1'b0;
            start_pulse  <= 1'b0;
            rstart_pulse <= 1'b0;
            stop_pulse   <= 1'b0;
            bus_busy     <= 1'b0;
        end else begin
            scl_p        <= scl_filt;
            sda_p        <= sda_filt;
            scl_rise     <= enable && !scl_p && scl_filt;
            scl_fall     <= enable && scl_p && !scl_filt;
            start_pulse  <= (cond == COND_START);
            rstart_pulse <= (cond == COND_RSTART);
            stop_pulse   <= (cond == COND_STOP);
            if (!enable || cond == COND_STOP) begin
                bus_busy <= 1'b0;
            end else if (cond == COND_START) begin
                bus_busy <= 1'b1;
            end
        end
    end

    // Bus-free timer restarts on any condition, a low line, or while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_cnt <= '0;
            bus_free <= 1'b0;
        end else if (!enable || !scl_filt || !sda_filt || cond != COND_NONE) begin
            free_cnt <= '0;
            bus_free <= 1'b0;
        end else if (!bus_busy && !bus_free) begin
            if (free_cnt == FREE_LAST) begin
                free_cnt <= FREE_SAT;
                bus_free <= 1'b1;
            end else begin
                free_cnt <= free_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_cond_detector.sv
// tb/tb_i2c_bus_cond_detector.sv - self-checking scoreboard bench for i2c_bus_cond_detector
module tb_i2c_bus_cond_detector;

    localparam int LAT  = 6;
    localparam int FREE = 64;

    localparam logic [4:0] EV_NONE   = 5'b00000;
    localparam logic [4:0] EV_RISE   = 5'b10000;
    localparam logic [4:0] EV_FALL   = 5'b01000;
    localparam logic [4:0] EV_START  = 5'b00100;
    localparam logic [4:0] EV_RSTART = 5'b00010;
    localparam logic [4:0] EV_STOP   = 5'b00001;

    typedef struct {
        logic [4:0] ev;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic scl_in;
    logic sda_in;
    logic scl_filt;
    logic sda_filt;
    logic scl_rise;
    logic scl_fall;
    logic start_pulse;
    logic rstart_pulse;
    logic stop_pulse;
    logic bus_busy;
    logic bus_free;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    i2c_bus_cond_detector dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .scl_filt    (scl_filt),
        .sda_filt    (sda_filt),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start_pulse (start_pulse),
        .rstart_pulse(rstart_pulse),
        .stop_pulse  (stop_pulse),
        .bus_busy    (bus_busy),
        .bus_free    (bus_free)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every observed pulse must match the oldest expected event, including its cycle.
    always @(negedge clk) begin : monitor
        logic [4:0] ev;
        exp_t       e;
        ev = {scl_rise, scl_fall, start_pulse, rstart_pulse, stop_pulse};
        if (ev != EV_NONE) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL event_unexpected got=%b at cyc=%0d required=none", ev, cyc);
            end else begin
                e = exp_q.pop_front();
                if (ev !== e.ev || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL event got=%b@%0d required=%b@%0d", ev, cyc, e.ev, e.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1);
    end

    task automatic drive(input logic scl, input logic sda, input logic [4:0] ev);
        exp_t e;
        scl_in = scl;
        sda_in = sda;
        if (ev != EV_NONE) begin
            e.ev  = ev;
            e.cyc = cyc + LAT;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        int r;
        int got;
        reset  = 1'b1;
        enable = 1'b1;
        scl_in = 1'b1;
        sda_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({scl_filt, sda_filt, bus_busy, bus_free} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_state got=%b required=1100", {scl_filt, sda_filt, bus_busy, bus_free});
        end
        checks++;
        if ({scl_rise, scl_fall, start_pulse, rstart_pulse, stop_pulse} !== EV_NONE) begin
            failures++;
            $display("FAIL reset_pulses got=%b required=00000",
                     {scl_rise, scl_fall, start_pulse, rstart_pulse, stop_pulse});
        end
        reset = 1'b0;
        r     = cyc;
        got   = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_free) begin
                got = cyc;
                break;
            end
        end
        checks++;
        if (got != r + FREE) begin
            failures++;
            $display("FAIL reset_bus_free_cycle got=%0d required=%0d", got, r + FREE);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_start();
        @(negedge clk);
        drive(1'b1, 1'b0, EV_START);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b0, EV_FALL);
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL start_missing got=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if ({bus_busy, bus_free} !== 2'b10) begin
            failures++;
            $display("FAIL start_busy_free got=%b required=10", {bus_busy, bus_free});
        end
    endtask

    task automatic test_rstart();
        @(negedge clk);
        drive(1'b0, 1'b1, EV_NONE);
        repeat (10) @(negedge clk);
        drive(1'b1, 1'b1, EV_RISE);
        repeat (10) @(negedge clk);
        drive(1'b1, 1'b0, EV_RSTART);
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rstart_missing got=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus_busy !== 1'b1) begin
            failures++;
            $display("FAIL rstart_busy got=%b required=1", bus_busy);
        end
    endtask

    task automatic test_stop();
        int s;
        int got;
        @(negedge clk);
        drive(1'b0, 1'b0, EV_FALL);
        repeat (10) @(negedge clk);
        drive(1'b1, 1'b0, EV_RISE);
        repeat (10) @(negedge clk);
        drive(1'b1, 1'b1, EV_STOP);
        s   = cyc;
        got = -1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus_free) begin
                got = cyc;
                break;
            end
        end
        checks++;
        if (got != s + LAT + FREE) begin
            failures++;
            $display("FAIL stop_bus_free_cycle got=%0d required=%0d", got, s + LAT + FREE);
        end
        checks++;
        if (bus_busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_busy got=%b required=0", bus_busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL stop_missing got=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_glitch();
        logic low_seen;
        @(negedge clk);
        drive(1'b1, 1'b0, EV_NONE);
        repeat (2) @(negedge clk);
        drive(1'b1, 1'b1, EV_NONE);
        low_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!sda_filt) low_seen = 1'b1;
        end
        checks++;
        if (low_seen !== 1'b0) begin
            failures++;
            $display("FAIL glitch_sda_filt got=low required=high");
        end
        checks++;
        if (bus_free !== 1'b1) begin
            failures++;
            $display("FAIL glitch_bus_free got=%b required=1", bus_free);
        end
        drive(1'b1, 1'b0, EV_START);
        repeat (3) @(negedge clk);
        drive(1'b1, 1'b1, EV_STOP);
        repeat (12) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL glitch3_missing got=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch3_busy got=%b required=0", bus_busy);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        drive(1'b0, 1'b0, EV_FALL);
        repeat (10) @(negedge clk);
        drive(1'b1, 1'b1, EV_RISE);
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL simul_missing got=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus_busy !== 1'b0) begin
            failures++;
            $display("FAIL simul_busy got=%b required=0", bus_busy);
        end
    endtask

    task automatic test_enable();
        int e;
        int got;
        @(negedge clk);
        drive(1'b1, 1'b0, EV_START);
        repeat (10) @(negedge clk);
        checks++;
        if (bus_busy !== 1'b1) begin
            failures++;
            $display("FAIL enable_pre_busy got=%b required=1", bus_busy);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_busy !== 1'b0) begin
            failures++;
            $display("FAIL enable_off_busy got=%b required=0", bus_busy);
        end
        drive(1'b0, 1'b0, EV_NONE);
        repeat (10) @(negedge clk);
        checks++;
        if (scl_filt !== 1'b0) begin
            failures++;
            $display("FAIL enable_off_scl_filt got=%b required=0", scl_filt);
        end
        drive(1'b1, 1'b0, EV_NONE);
        repeat (10) @(negedge clk);
        drive(1'b1, 1'b1, EV_NONE);
        repeat (12) @(negedge clk);
        checks++;
        if ({bus_busy, bus_free} !== 2'b00) begin
            failures++;
            $display("FAIL enable_off_state got=%b required=00", {bus_busy, bus_free});
        end
        enable = 1'b1;
        e      = cyc;
        got    = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_free) begin
                got = cyc;
                break;
            end
        end
        checks++;
        if (got != e + FREE) begin
            failures++;
            $display("FAIL enable_on_bus_free_cycle got=%0d required=%0d", got, e + FREE);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL enable_missing got=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_rstart();
        test_stop();
        test_glitch();
        test_simultaneous();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
